imem_loader: RTL

Boot/reload controller for the writable instruction memory of the single-cycle MIPS core. On a Start command it halts the CPU and accepts a stream of bytes over a valid/ready handshake. It packs each four bytes into a 32-bit big-endian instruction word and writes that word into consecutive instruction-memory words from index 0. When loading completes it releases the CPU; on a stall it aborts with an error flag.

---
 rtl/imem_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot/reload controller for the writable instruction memory.
//               Holds the CPU, receives a byte stream over valid/ready, packs
//               four bytes (MSB first) into each instruction word and writes
//               consecutive words from index 0. Aborts with a sticky error if
//               the stream stalls for too long.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
  parameter int AW      = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic          Clk,
  input  logic          Clrn,
  input  logic          Start,
  input  logic [AW:0]   Len,
  input  logic [7:0]    Byte_in,
  input  logic          Byte_valid,
  output logic          Byte_ready,
  output logic          Mem_we,
  output logic [AW-1:0] Mem_addr,
  output logic [31:0]   Mem_wdata,
  output logic          Cpu_run,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  localparam int          TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [AW:0] MAX_LEN  = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_LOAD   = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [AW:0]   len_q, len_nxt;
  logic [AW-1:0] widx, widx_nxt;
  logic [1:0]    bcnt, bcnt_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [23:0]   word, word_nxt;

  logic          ready_nxt, we_nxt, run_nxt, busy_nxt, done_nxt, err_nxt;
  logic [AW-1:0] addr_nxt;
  logic [31:0]   wdata_nxt;

  logic          xfer;
  logic          len_ok;
  logic          last_word;

  assign xfer      = Byte_valid & Byte_ready;
  assign len_ok    = (Len != '0) && (Len <= MAX_LEN);
  assign last_word = ({1'b0, widx} == (len_q - 1'b1));

  // State and all registered outputs; async clear returns to the run state.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      state      <= S_RUN;
      len_q      <= '0;
      widx       <= '0;
      bcnt       <= '0;
      timer      <= '0;
      word       <= '0;
      Byte_ready <= 1'b0;
      Mem_we     <= 1'b0;
      Mem_addr   <= '0;
      Mem_wdata  <= '0;
      Cpu_run    <= 1'b1;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      len_q      <= len_nxt;
      widx       <= widx_nxt;
      bcnt       <= bcnt_nxt;
      timer      <= timer_nxt;
      word       <= word_nxt;
      Byte_ready <= ready_nxt;
      Mem_we     <= we_nxt;
      Mem_addr   <= addr_nxt;
      Mem_wdata  <= wdata_nxt;
      Cpu_run    <= run_nxt;
      Busy       <= busy_nxt;
      Done       <= done_nxt;
      Err        <= err_nxt;
    end
  end

  // Next-state and next-output logic; strobes default low, everything else holds.
  always_comb begin
    state_nxt = state;
    len_nxt   = len_q;
    widx_nxt  = widx;
    bcnt_nxt  = bcnt;
    timer_nxt = timer;
    word_nxt  = word;
    ready_nxt = Byte_ready;
    we_nxt    = 1'b0;
    addr_nxt  = Mem_addr;
    wdata_nxt = Mem_wdata;
    run_nxt   = Cpu_run;
    busy_nxt  = Busy;
    done_nxt  = 1'b0;
    err_nxt   = Err;

    case (state)
      S_RUN: begin
        if (Start && len_ok) begin
          len_nxt   = Len;
          widx_nxt  = '0;
          bcnt_nxt  = '0;
          timer_nxt = '0;
          err_nxt   = 1'b0;
          state_nxt = S_LOAD;
          run_nxt   = 1'b0;
          busy_nxt  = 1'b1;
          ready_nxt = 1'b1;
        end
      end

      S_LOAD: begin
        if (xfer) begin
          timer_nxt = '0;
          bcnt_nxt  = bcnt + 1'b1;
          word_nxt  = {word[15:0], Byte_in};
          if (bcnt == 2'd3) begin
            state_nxt = S_WRITE;
            ready_nxt = 1'b0;
            we_nxt    = 1'b1;
            addr_nxt  = widx;
            wdata_nxt = {word, Byte_in};
          end
        end else if (timer == TOUT_LAST) begin
          // Stalled producer: give the CPU back, drop any partial word.
          state_nxt = S_RUN;
          err_nxt   = 1'b1;
          run_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          ready_nxt = 1'b0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end

      S_WRITE: begin
        timer_nxt = '0;
        if (last_word) begin
          state_nxt = S_FINISH;
          done_nxt  = 1'b1;
        end else begin
          widx_nxt  = widx + 1'b1;
          state_nxt = S_LOAD;
          ready_nxt = 1'b1;
        end
      end

      S_FINISH: begin
        state_nxt = S_RUN;
        run_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end

      default: begin
        state_nxt = S_RUN;
      end
    endcase
  end

endmodule
`default_nettype wire
